// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch stage: the fetch FSM
// state type, the canonical NOP encoding, the default reset PC and the
// {pc, instr} entry that travels through the fetch queue.
package fetch_pkg;

  // FETCH_RUN issues reads and accepts responses; FETCH_DROP burns exactly
  // one cycle so that a response belonging to the old stream is thrown away.
  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_DROP = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Two-entry FIFO of fetch entries sitting between the BRAM response and the
// decoder handshake. Push and pop may happen in the same cycle at any fill
// level; flush empties the queue and takes priority over push and pop.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   push_i       write pushEntry_i at the tail this cycle
//   pushEntry_i  entry to be written
//   pop_i        drop the head entry this cycle
//   flush_i      discard every entry
//   head_o       current head entry (reset contents when nothing was pushed)
//   count_o      number of valid entries, 0..2
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  fetch_entry_t pushEntry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rdPtr_q, rdPtr_d;
  logic         wrPtr_q, wrPtr_d;
  logic [1:0]   count_q, count_d;
  logic         doPush;
  logic         doPop;

  // Qualify the requests against the fill level so the FIFO can never
  // underflow or overwrite a live entry, then work out the new pointers and
  // count. A flush resets the pointers, which is all it takes to empty it.
  always_comb begin
    doPop   = pop_i && (count_q != 2'd0);
    doPush  = push_i && ((count_q != 2'd2) || doPop);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = 1'b0;
      wrPtr_d = 1'b0;
      count_d = 2'd0;
    end else begin
      if (doPush) wrPtr_d = ~wrPtr_q;
      if (doPop)  rdPtr_d = ~rdPtr_q;
      count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage. Reset contents are a NOP at the reset PC so the decoder
  // sees a harmless instruction on out_instr/out_pc straight out of reset.
  // When full, a push together with a pop overwrites the slot being popped,
  // which is safe because the head is read combinationally this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= fetch_entry_t'{pc: RESET_PC, instr: INSTR_NOP};
      end
    end else if (doPush && !flush_i) begin
      mem_q[wrPtr_q] <= pushEntry_i;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: holds the PC, issues reads to a synchronous
// instruction BRAM (one-cycle read latency), queues fetched words with their
// PC in a 2-entry buffer and hands them to the decoder over valid/ready.
// Execute can redirect the PC at any time; a read that is still in flight
// when a redirect arrives is discarded via a one-cycle FETCH_DROP state.
//
// Optional feature macro: IMEM_WRITE_EN adds an instruction-memory write
// port (iw_* inputs, imem_we/imem_wdata outputs). A write steals the BRAM
// for one cycle and blocks fetch issue in that cycle. Queued words are not
// snooped; software must jump to rewritten code before executing it.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   imem_en, imem_addr         BRAM enable and word address
//   imem_rdata                 BRAM read data, valid the cycle after a read
//   redirect_valid/_pc         PC change request from execute
//   out_valid/out_ready        decoder handshake
//   out_instr, out_pc          head instruction and its byte address
//   iw_valid/iw_addr/iw_data   write request (IMEM_WRITE_EN only)
//   imem_we, imem_wdata        BRAM write port (IMEM_WRITE_EN only)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc
`ifdef IMEM_WRITE_EN
  ,
  input  logic              iw_valid,
  input  logic [31:0]       iw_addr,
  input  logic [31:0]       iw_data,
  output logic              imem_we,
  output logic [31:0]       imem_wdata
`endif
);

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       reqPc_q, reqPc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  logic              writeReq;
  logic [ADDR_W-1:0] writeAddr;
  fetch_entry_t      head;
  fetch_entry_t      pushEntry;
  logic              unusedBits;

  // Write-port plumbing. Without the feature the write request is tied off,
  // so the fetch logic below is identical in both builds.
`ifdef IMEM_WRITE_EN
  assign writeReq   = iw_valid;
  assign writeAddr  = iw_addr[ADDR_W+1:2];
  assign imem_we    = iw_valid;
  assign imem_wdata = iw_data;
  assign unusedBits = ^{redirect_pc[1:0], iw_addr[1:0], iw_addr[31:ADDR_W+2]};
`else
  assign writeReq   = 1'b0;
  assign writeAddr  = '0;
  assign unusedBits = ^redirect_pc[1:0];
`endif

  // Handshake, issue and push decisions. Issue is allowed only if, after
  // this cycle's pop, the queue plus the read already in flight leaves room
  // for the word being requested now; that keeps the 2-entry buffer from
  // ever overflowing. Issue is gated with rstn so the BRAM stays idle while
  // reset is held. A redirect blocks both issue and the push of whatever
  // response is arriving, since that word belongs to the old stream.
  always_comb begin
    pop       = out_valid && out_ready;
    occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = rstn && (state_q == FETCH_RUN) && !redirect_valid &&
                (occupancy <= 3'd1) && !writeReq;
    push      = inflight_q && (state_q == FETCH_RUN) && !redirect_valid;
    pushEntry = fetch_entry_t'{pc: reqPc_q, instr: imem_rdata};
  end

  // Next-state logic for the PC, the issued-address register and the FSM.
  // A redirect while a read is outstanding moves to FETCH_DROP for one cycle;
  // a redirect arriving during FETCH_DROP just retargets the PC.
  always_comb begin
    state_d    = FETCH_RUN;
    pc_d       = pc_q;
    reqPc_d    = reqPc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      if ((state_q == FETCH_RUN) && inflight_q) begin
        state_d = FETCH_DROP;
      end
    end else if (issue) begin
      pc_d    = pc_q + 32'd4;
      reqPc_d = pc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      reqPc_q    <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      reqPc_q    <= reqPc_d;
      inflight_q <= inflight_d;
    end
  end

  // BRAM request: a pending write takes the port, otherwise the current PC
  // is presented and the enable follows the issue decision.
  always_comb begin
    imem_en   = issue || writeReq;
    imem_addr = writeReq ? writeAddr : pc_q[ADDR_W+1:2];
  end

  fetch_buffer #(
    .RESET_PC(RESET_PC)
  ) u_buffer (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (push),
    .pushEntry_i(pushEntry),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .head_o     (head),
    .count_o    (count)
  );

  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. The BRAM model returns the word address as
// data (word k = k) unless a word has been written through the optional
// write port. Cycle 0 is the cycle in which rstn is released.
module tb_fetch_unit;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              rstn;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
`ifdef IMEM_WRITE_EN
  logic              iw_valid;
  logic [31:0]       iw_addr;
  logic [31:0]       iw_data;
  logic              imem_we;
  logic [31:0]       imem_wdata;
  logic              patchValid;
  logic [ADDR_W-1:0] patchAddr;
  logic [31:0]       patchData;
`endif

  int total;
  int bad;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
`ifdef IMEM_WRITE_EN
    ,
    .iw_valid      (iw_valid),
    .iw_addr       (iw_addr),
    .iw_data       (iw_data),
    .imem_we       (imem_we),
    .imem_wdata    (imem_wdata)
`endif
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous BRAM model with one-cycle read latency. Word k reads back as
  // k, except a single word that may be overwritten via the write port.
  always @(posedge clk) begin
    if (imem_en) begin
      imem_rdata <= {{(32-ADDR_W){1'b0}}, imem_addr};
`ifdef IMEM_WRITE_EN
      if (patchValid && (patchAddr == imem_addr)) imem_rdata <= patchData;
      if (imem_we) begin
        patchValid <= 1'b1;
        patchAddr  <= imem_addr;
        patchData  <= imem_wdata;
      end
`endif
    end
  end

  // Runaway guard: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic nextCycle;
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rstn           = 1'b0;
    imem_rdata     = 32'h0;
`ifdef IMEM_WRITE_EN
    iw_valid       = 1'b0;
    iw_addr        = 32'h0;
    iw_data        = 32'h0;
    patchValid     = 1'b0;
    patchAddr      = '0;
    patchData      = 32'h0;
`endif
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (2) nextCycle;

    // Reset values
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_instr", out_instr, 32'h0000_0013);
    checkOutput("rst_pc", out_pc, 32'h0);
    checkOutput("rst_en", {31'b0, imem_en}, 32'd0);

    // Cycle 0: first issue at pc 0
    rstn = 1'b1;
    #1;
    checkOutput("c0_en", {31'b0, imem_en}, 32'd1);
    checkOutput("c0_addr", {18'b0, imem_addr}, 32'd0);

    // Cycle 1: nothing delivered yet, second issue at word 1
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("c1_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("c1_addr", {18'b0, imem_addr}, 32'd1);

    // Cycles 2..7: one instruction per cycle, pc 4i, instr i
    for (int i = 0; i < 6; i++) begin
      nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("stream_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stream_pc", out_pc, 32'(4 * i));
      checkOutput("stream_instr", out_instr, 32'(i));
    end

    // Cycles 8..12: back-pressure, head held at word 6, fetch stalls
    for (int i = 0; i < 5; i++) begin
      nextCycle; applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("bp_pc", out_pc, 32'd24);
      checkOutput("bp_instr", out_instr, 32'd6);
      checkOutput("bp_en", {31'b0, imem_en}, 32'd0);
    end

    // Cycles 13..16: release; words 6,7,8,9 in order, issue resumes at 8
    for (int i = 0; i < 4; i++) begin
      nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("rel_pc", out_pc, 32'(24 + 4 * i));
      checkOutput("rel_instr", out_instr, 32'(6 + i));
      checkOutput("rel_addr", {18'b0, imem_addr}, 32'(8 + i));
    end

    // Cycle 17 (t): redirect to 0x103 with a read in flight
    nextCycle; applyStimulus(1'b1, 32'h0000_0103, 1'b1);
    checkOutput("rd_en_t", {31'b0, imem_en}, 32'd0);
    // t+1: FETCH_DROP, no issue, stale word not queued
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rd_valid_t1", {31'b0, out_valid}, 32'd0);
    checkOutput("rd_en_t1", {31'b0, imem_en}, 32'd0);
    // t+2: issue at 0x100 (word 64)
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rd_en_t2", {31'b0, imem_en}, 32'd1);
    checkOutput("rd_addr_t2", {18'b0, imem_addr}, 32'd64);
    checkOutput("rd_valid_t2", {31'b0, out_valid}, 32'd0);
    // t+3
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rd_valid_t3", {31'b0, out_valid}, 32'd0);
    // t+4: target delivered
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rd_valid_t4", {31'b0, out_valid}, 32'd1);
    checkOutput("rd_pc_t4", out_pc, 32'h100);
    checkOutput("rd_instr_t4", out_instr, 32'd64);
    // Cycle 22
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rd_pc_t5", out_pc, 32'h104);
    checkOutput("rd_instr_t5", out_instr, 32'd65);

    // Cycles 23..24: stall to fill the queue to 2 (head 0x108)
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("fill_pc0", out_pc, 32'h108);
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("fill_pc1", out_pc, 32'h108);
    checkOutput("fill_en", {31'b0, imem_en}, 32'd0);
    // Cycle 25: redirect to 0x200 together with a pop at count 2
    nextCycle; applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    checkOutput("rp_pc_t", out_pc, 32'h108);
    checkOutput("rp_en_t", {31'b0, imem_en}, 32'd0);
    // Cycle 26: no FETCH_DROP needed, issue at word 128
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rp_valid_t1", {31'b0, out_valid}, 32'd0);
    checkOutput("rp_addr_t1", {18'b0, imem_addr}, 32'd128);
    // Cycle 27
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rp_valid_t2", {31'b0, out_valid}, 32'd0);
    // Cycle 28: target delivered, old stream gone
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rp_valid_t3", {31'b0, out_valid}, 32'd1);
    checkOutput("rp_pc_t3", out_pc, 32'h200);
    checkOutput("rp_instr_t3", out_instr, 32'd128);
    // Cycle 29
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rp_pc_t4", out_pc, 32'h204);
    checkOutput("rp_instr_t4", out_instr, 32'd129);

    // Cycle 30: redirect near the top of the address space
    nextCycle; applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    checkOutput("wr_en_t", {31'b0, imem_en}, 32'd0);
    // Cycle 31: FETCH_DROP
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wr_en_t1", {31'b0, imem_en}, 32'd0);
    // Cycle 32
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wr_addr_t2", {18'b0, imem_addr}, 32'h3FFE);
    // Cycle 33
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wr_addr_t3", {18'b0, imem_addr}, 32'h3FFF);
    // Cycle 34: address wrapped to 0
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wr_addr_t4", {18'b0, imem_addr}, 32'h0);
    checkOutput("wr_pc_t4", out_pc, 32'hFFFF_FFF8);
    checkOutput("wr_instr_t4", out_instr, 32'h3FFE);
    // Cycle 35
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wr_pc_t5", out_pc, 32'hFFFF_FFFC);
    checkOutput("wr_instr_t5", out_instr, 32'h3FFF);
    // Cycle 36: pc wrapped to 0
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wr_pc_t6", out_pc, 32'h0);
    checkOutput("wr_instr_t6", out_instr, 32'h0);

    // Cycle 37: asynchronous reset mid-stream clears everything at once
    nextCycle;
    rstn = 1'b0;
    #1;
    checkOutput("mr_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mr_pc", out_pc, 32'h0);
    checkOutput("mr_instr", out_instr, 32'h0000_0013);
    checkOutput("mr_en", {31'b0, imem_en}, 32'd0);
    nextCycle;
    rstn = 1'b1;
    #1;
    // New cycle 0
    checkOutput("mr_en_c0", {31'b0, imem_en}, 32'd1);
    checkOutput("mr_addr_c0", {18'b0, imem_addr}, 32'd0);
    // New cycle 1: stale BRAM data from before reset must not be queued
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mr_valid_c1", {31'b0, out_valid}, 32'd0);
    // New cycle 2
    nextCycle; applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mr_valid_c2", {31'b0, out_valid}, 32'd1);
    checkOutput("mr_pc_c2", out_pc, 32'h0);
    checkOutput("mr_instr_c2", out_instr, 32'h0);

`ifdef IMEM_WRITE_EN
    // Write 0xDEADBEEF to byte address 0x40 (word 16); fetch stalls
    nextCycle;
    iw_valid = 1'b1;
    iw_addr  = 32'h0000_0040;
    iw_data  = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("iw_we", {31'b0, imem_we}, 32'd1);
    checkOutput("iw_en", {31'b0, imem_en}, 32'd1);
    checkOutput("iw_addr", {18'b0, imem_addr}, 32'd16);
    checkOutput("iw_wdata", imem_wdata, 32'hDEAD_BEEF);
    // Jump to the rewritten word
    nextCycle;
    iw_valid = 1'b0;
    applyStimulus(1'b1, 32'h0000_0040, 1'b1);
    checkOutput("iw_we_off", {31'b0, imem_we}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      nextCycle; applyStimulus(1'b0, 32'h0, 1'b0);
      if (out_valid) break;
    end
    checkOutput("iw_wait", {31'b0, out_valid}, 32'd1);
    checkOutput("iw_pc", out_pc, 32'h40);
    checkOutput("iw_instr", out_instr, 32'hDEAD_BEEF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the single-cycle control decoder. Holds the program counter, issues reads to a synchronous instruction BRAM (1-cycle read latency), and buffers fetched words with their PC in a 2-entry queue. Hands instructions downstream with a valid/ready handshake and accepts PC redirects from execute (taken branch, JAL, JALR).

## Interface
Parameters:
- ADDR_W, 14: instruction memory word-address width (16K words).
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- imem_en  out  1  BRAM enable; a read issued in cycle t returns on imem_rdata in t+1.
- imem_addr  out  ADDR_W  BRAM word address, = pc[ADDR_W+1:2] on fetch.
- imem_rdata  in  32  BRAM read data.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  decoder consumes the head entry when out_valid && out_ready.
- out_instr  out  32  instruction word to the decoder.
- out_pc  out  32  byte address of out_instr.
- iw_valid, iw_addr[31:0], iw_data[31:0]  in  instruction-memory write request (present only with IMEM_WRITE_EN).
- imem_we  out  1, imem_wdata  out  32  BRAM write port (present only with IMEM_WRITE_EN).

## Operation
- State: pc (32 b), inflight (1 b), queue count (0..2), FSM state.
- Reset values: pc = RESET_PC, queue empty, inflight = 0, state = FETCH_RUN; out_valid = 0, out_instr = 32'h0000_0013 (NOP), out_pc = RESET_PC, imem_en = 0, imem_we = 0.
- Pop = out_valid && out_ready.
- Issue condition: state == FETCH_RUN && !redirect_valid && (count + inflight - pop) <= 1 && !iw_valid. On issue: imem_en = 1, inflight <= 1, pc <= pc + 4 (mod 2^32; imem_addr wraps naturally).
- Response: when inflight && state == FETCH_RUN, push {pc_of_issue, imem_rdata} into the queue at the end of the cycle. Push and pop in the same cycle are allowed at any count.
- Redirect: pc <= {redirect_pc[31:2], 2'b00}; queue flushed; no issue in that cycle. If a read is in flight, state <= FETCH_DROP and that response is discarded. Redirect beats a simultaneous pop or push.
- FSM: FETCH_RUN -> FETCH_DROP on redirect with inflight = 1. FETCH_DROP -> FETCH_RUN after one cycle; the stale response is discarded, with no issue during FETCH_DROP. A redirect in FETCH_DROP only updates pc.
- out_* is driven from the queue head. out_instr/out_pc are held stable while out_valid && !out_ready.

## Timing
- After rstn deasserts: first issue in cycle 0, push at end of cycle 1, out_valid = 1 in cycle 2.
- With out_ready held high, throughput is 1 instruction/cycle.
- Redirect in cycle t: issue at new pc in t+1 (t+2 if FETCH_DROP), out_valid for the target in t+3 (t+4).
- rstn assertion mid-operation clears everything immediately. Any in-flight BRAM response arriving after release is ignored because inflight = 0.

## Configuration
- IMEM_WRITE_EN defined: iw_* ports, imem_we and imem_wdata exist. When iw_valid = 1: imem_we = 1, imem_en = 1, imem_addr = iw_addr[ADDR_W+1:2], imem_wdata = iw_data, and no fetch is issued that cycle. No snooping of queued words: software must redirect (jump) before executing rewritten code.
- IMEM_WRITE_EN undefined: these ports are absent and the BRAM is read-only.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t (FETCH_RUN, FETCH_DROP);
  - INSTR_NOP = 32'h0000_0013;
  - the default RESET_PC;
  - the fetch entry struct {pc, instr}.
- Sub-module fetch_buffer: 2-entry FIFO of fetch entries with push, pop, flush and count.

## Test plan
- Reset release, out_ready = 1, BRAM word k = k: out_pc 0,4,8,... with out_instr 0,1,2,... on consecutive cycles from cycle 2.
- out_ready held low for 5 cycles: queue fills to 2, imem_en stops; out_instr/out_pc stay stable; no word lost or duplicated on release.
- redirect_pc = 32'h0000_0103 while a read is in flight: stale word dropped, next delivered out_pc = 32'h100, in cycle t+4.
- Redirect in the same cycle as a pop with count = 2: queue empties; no instruction from the old stream appears afterwards.
- Fetch at pc = 32'hFFFF_FFFC: next out_pc = 32'h0, and imem_addr wraps to 0.
- IMEM_WRITE_EN: iw_valid with iw_addr = 32'h40, iw_data = 32'hDEADBEEF. Result: imem_we pulse at word 16 and fetch stalls that cycle. After a redirect to 32'h40, out_instr = 32'hDEADBEEF.
